// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I definitions: register index/data types and the write-request payload.
package riscv_32i_defs_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

    localparam reg_idx_t X0 = 5'd0;

    typedef struct packed {
        logic     live;
        reg_idx_t rd;
        xlen_t    data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// In-order buffer of pending register writes with kill-by-register and two
// register-match lookups used for decode hazard detection.
module rf_wr_fifo
    import riscv_32i_defs_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  rf_wr_req_t                     push_req,
    input  logic                           pop,
    output rf_wr_req_t                     head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    input  logic                           kill_en,
    input  reg_idx_t                       kill_reg,
    input  reg_idx_t                       match_reg_1,
    input  reg_idx_t                       match_reg_2,
    output logic                           match_1,
    output logic                           match_2
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rf_wr_req_t        entries [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    assign head = entries[rd_ptr];

    // Entries outside the occupied window always have live cleared, so
    // live alone identifies a pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (kill_en && entries[i].rd == kill_reg) begin
                    entries[i].live <= 1'b0;
                end
            end
            if (pop) begin
                entries[rd_ptr].live <= 1'b0;
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push) begin
                entries[wr_ptr] <= push_req;
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        match_1 = 1'b0;
        match_2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entries[i].live && entries[i].rd == match_reg_1) match_1 = 1'b1;
            if (entries[i].live && entries[i].rd == match_reg_2) match_2 = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_wr_ctrl.sv
// Write-port arbiter for reg_file: ALU writeback has priority, load responses
// are bypassed when possible or buffered in order, and younger ALU writes kill older loads.
module reg_file_wr_ctrl
    import riscv_32i_defs_pkg::*;
#(
    parameter int unsigned LD_FIFO_DEPTH  = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 alu_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]            alu_wr_reg,
    input  logic [DATA_WIDTH-1:0]                alu_wr_data,
    input  logic                                 ld_valid,
    output logic                                 ld_ready,
    input  logic [REG_ADDR_WIDTH-1:0]            ld_wr_reg,
    input  logic [DATA_WIDTH-1:0]                ld_wr_data,
    input  logic [REG_ADDR_WIDTH-1:0]            chk_reg_1,
    input  logic [REG_ADDR_WIDTH-1:0]            chk_reg_2,
    output logic                                 chk_busy_1,
    output logic                                 chk_busy_2,
    output logic                                 wr_en,
    output logic [REG_ADDR_WIDTH-1:0]            wr_reg,
    output logic [DATA_WIDTH-1:0]                wr_data,
    output logic [$clog2(LD_FIFO_DEPTH+1)-1:0]   ld_count
);

    localparam int unsigned CNT_W = $clog2(LD_FIFO_DEPTH + 1);

    logic       alu_issue;
    logic       ld_xfer;
    logic       ld_keep;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic       bypass;
    logic       match_1;
    logic       match_2;
    rf_wr_req_t head;
    rf_wr_req_t push_req;

    assign ld_ready   = rst_n && (ld_count < CNT_W'(LD_FIFO_DEPTH));
    assign ld_xfer    = ld_valid && ld_ready;
    assign alu_issue  = alu_wr_en && (alu_wr_reg != X0);
    // A load to x0, or one overwritten by a same-cycle ALU write, completes its handshake and vanishes.
    assign ld_keep    = ld_xfer && (ld_wr_reg != X0) && !(alu_issue && ld_wr_reg == alu_wr_reg);
    assign fifo_empty = (ld_count == '0);
    assign fifo_pop   = !alu_issue && !fifo_empty;
    assign bypass     = !alu_issue && fifo_empty && ld_keep;
    assign fifo_push  = ld_keep && !bypass;
    assign push_req   = '{live: 1'b1, rd: reg_idx_t'(ld_wr_reg), data: xlen_t'(ld_wr_data)};

    rf_wr_fifo #(
        .DEPTH (LD_FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .push_req    (push_req),
        .pop         (fifo_pop),
        .head        (head),
        .count       (ld_count),
        .kill_en     (alu_issue),
        .kill_reg    (reg_idx_t'(alu_wr_reg)),
        .match_reg_1 (reg_idx_t'(chk_reg_1)),
        .match_reg_2 (reg_idx_t'(chk_reg_2)),
        .match_1     (match_1),
        .match_2     (match_2)
    );

    assign chk_busy_1 = (chk_reg_1 != X0) && ((wr_en && wr_reg == chk_reg_1) || match_1);
    assign chk_busy_2 = (chk_reg_2 != X0) && ((wr_en && wr_reg == chk_reg_2) || match_2);

    // One write per cycle: ALU, then FIFO head, then bypassed load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else if (alu_issue) begin
            wr_en   <= 1'b1;
            wr_reg  <= alu_wr_reg;
            wr_data <= alu_wr_data;
        end else if (fifo_pop) begin
            wr_en <= head.live;
            if (head.live) begin
                wr_reg  <= REG_ADDR_WIDTH'(head.rd);
                wr_data <= DATA_WIDTH'(head.data);
            end
        end else if (bypass) begin
            wr_en   <= 1'b1;
            wr_reg  <= ld_wr_reg;
            wr_data <= ld_wr_data;
        end else begin
            wr_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_wr_ctrl.sv
// Self-checking bench for reg_file_wr_ctrl: directed scenarios with an ordered
// write scoreboard, then a random run checked against an architectural register model.
module tb_reg_file_wr_ctrl;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_wr_t;

    logic        clk;
    logic        rst_n;
    logic        alu_wr_en;
    logic [4:0]  alu_wr_reg;
    logic [31:0] alu_wr_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_wr_reg;
    logic [31:0] ld_wr_data;
    logic [4:0]  chk_reg_1;
    logic [4:0]  chk_reg_2;
    logic        chk_busy_1;
    logic        chk_busy_2;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [1:0]  ld_count;

    int          checks;
    int          errors;
    bit          sb_en;
    exp_wr_t     exp_q[$];
    logic [31:0] rf   [32];
    logic [31:0] arch [32];

    reg_file_wr_ctrl #(
        .LD_FIFO_DEPTH  (2),
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_wr_en   (alu_wr_en),
        .alu_wr_reg  (alu_wr_reg),
        .alu_wr_data (alu_wr_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_wr_reg   (ld_wr_reg),
        .ld_wr_data  (ld_wr_data),
        .chk_reg_1   (chk_reg_1),
        .chk_reg_2   (chk_reg_2),
        .chk_busy_1  (chk_busy_1),
        .chk_busy_2  (chk_busy_2),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .ld_count    (ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reg_file: commits the write port on the posedge after issue.
    always @(posedge clk) begin
        if (wr_en === 1'b1 && wr_reg != 5'd0) rf[wr_reg] <= wr_data;
    end

    // Write monitor: pops the scoreboard on each issued write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            checks++;
            if (wr_reg === 5'd0) begin
                errors++;
                $display("FAIL x0_write: wr_en with wr_reg=0 data=%h", wr_data);
            end
            if (sb_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got reg=%0d data=%h, none expected", wr_reg, wr_data);
                end else begin
                    exp_wr_t e;
                    e = exp_q.pop_front();
                    if (wr_reg !== e.rd || wr_data !== e.data) begin
                        errors++;
                        $display("FAIL sb_order: got reg=%0d data=%h, expected reg=%0d data=%h",
                                 wr_reg, wr_data, e.rd, e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_wr_en   = 1'b0;
        alu_wr_reg  = 5'd0;
        alu_wr_data = 32'd0;
        ld_valid    = 1'b0;
        ld_wr_reg   = 5'd0;
        ld_wr_data  = 32'd0;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        chk_reg_1 = 5'd0;
        chk_reg_2 = 5'd0;
        step();
        step();
        chk("reset_wr_en",    32'(wr_en),    32'd0);
        chk("reset_wr_reg",   32'(wr_reg),   32'd0);
        chk("reset_wr_data",  wr_data,       32'd0);
        chk("reset_ld_count", 32'(ld_count), 32'd0);
        chk("reset_ld_ready", 32'(ld_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_ld_ready", 32'(ld_ready), 32'd1);
    endtask

    task automatic test_lone_load();
        chk_reg_1  = 5'd7;
        ld_valid   = 1'b1;
        ld_wr_reg  = 5'd7;
        ld_wr_data = 32'hDEADBEEF;
        expect_wr(5'd7, 32'hDEADBEEF);
        chk("lone_ld_ready", 32'(ld_ready), 32'd1);
        step();
        idle_inputs();
        chk("lone_wr_en",    32'(wr_en),      32'd1);
        chk("lone_wr_reg",   32'(wr_reg),     32'd7);
        chk("lone_wr_data",  wr_data,         32'hDEADBEEF);
        chk("lone_ld_count", 32'(ld_count),   32'd0);
        chk("lone_busy",     32'(chk_busy_1), 32'd1);
        step();
        chk("lone_rf_x7",    rf[7],           32'hDEADBEEF);
        chk("lone_busy_clr", 32'(chk_busy_1), 32'd0);
    endtask

    task automatic test_collision();
        chk_reg_1   = 5'd4;
        alu_wr_en   = 1'b1;
        alu_wr_reg  = 5'd3;
        alu_wr_data = 32'h11;
        ld_valid    = 1'b1;
        ld_wr_reg   = 5'd4;
        ld_wr_data  = 32'h22;
        expect_wr(5'd3, 32'h11);
        expect_wr(5'd4, 32'h22);
        step();
        idle_inputs();
        chk("coll_wr_reg0",  32'(wr_reg),     32'd3);
        chk("coll_count1",   32'(ld_count),   32'd1);
        chk("coll_busy_x4",  32'(chk_busy_1), 32'd1);
        step();
        chk("coll_wr_en1",   32'(wr_en),      32'd1);
        chk("coll_wr_reg1",  32'(wr_reg),     32'd4);
        chk("coll_wr_data1", wr_data,         32'h22);
        chk("coll_count0",   32'(ld_count),   32'd0);
        step();
        chk("coll_rf_x3",    rf[3],           32'h11);
        chk("coll_rf_x4",    rf[4],           32'h22);
    endtask

    task automatic test_backpressure();
        int ld_i;
        bit saw_full;
        bit xfer;
        ld_i     = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 3; c++) expect_wr(5'(10 + c), 32'h100 + 32'(c));
        for (int c = 0; c < 3; c++) expect_wr(5'(1 + c), 32'hA1 + 32'(c));
        for (int c = 0; c < 20 && (c < 3 || ld_i < 3); c++) begin
            alu_wr_en   = (c < 3);
            alu_wr_reg  = 5'(10 + c);
            alu_wr_data = 32'h100 + 32'(c);
            ld_valid    = (ld_i < 3);
            ld_wr_reg   = 5'(1 + ld_i);
            ld_wr_data  = 32'hA1 + 32'(ld_i);
            if (ld_count == 2'd2) begin
                saw_full = 1'b1;
                chk("bp_ready_full", 32'(ld_ready), 32'd0);
            end
            xfer = ld_valid && ld_ready;
            step();
            if (xfer) ld_i++;
        end
        idle_inputs();
        for (int c = 0; c < 10 && (ld_count != 2'd0 || wr_en); c++) step();
        step();
        chk("bp_saw_full", 32'(saw_full), 32'd1);
        chk("bp_all_xfer", 32'(ld_i),     32'd3);
        chk("bp_drained",  32'(ld_count), 32'd0);
        chk("bp_rf_x1",    rf[1],         32'hA1);
        chk("bp_rf_x2",    rf[2],         32'hA2);
        chk("bp_rf_x3",    rf[3],         32'hA3);
        chk("bp_rf_x12",   rf[12],        32'h102);
    endtask

    task automatic test_waw();
        chk_reg_1   = 5'd5;
        alu_wr_en   = 1'b1;
        alu_wr_reg  = 5'd6;
        alu_wr_data = 32'h66;
        ld_valid    = 1'b1;
        ld_wr_reg   = 5'd5;
        ld_wr_data  = 32'hAA;
        expect_wr(5'd6, 32'h66);
        expect_wr(5'd5, 32'hBB);
        step();
        idle_inputs();
        chk("waw_count_buf", 32'(ld_count),   32'd1);
        chk("waw_busy_buf",  32'(chk_busy_1), 32'd1);
        alu_wr_en   = 1'b1;
        alu_wr_reg  = 5'd5;
        alu_wr_data = 32'hBB;
        step();
        idle_inputs();
        chk("waw_alu_reg",   32'(wr_reg),     32'd5);
        chk("waw_alu_data",  wr_data,         32'hBB);
        chk("waw_busy_alu",  32'(chk_busy_1), 32'd1);
        step();
        chk("waw_kill_wr_en", 32'(wr_en),      32'd0);
        chk("waw_count_0",    32'(ld_count),   32'd0);
        chk("waw_busy_clr",   32'(chk_busy_1), 32'd0);
        chk("waw_rf_x5",      rf[5],           32'hBB);
        step();
        chk("waw_rf_x5_hold", rf[5],           32'hBB);
    endtask

    task automatic test_x0();
        chk_reg_1   = 5'd0;
        alu_wr_en   = 1'b1;
        alu_wr_reg  = 5'd0;
        alu_wr_data = 32'hFF;
        ld_valid    = 1'b1;
        ld_wr_reg   = 5'd0;
        ld_wr_data  = 32'h1;
        chk("x0_ld_ready", 32'(ld_ready), 32'd1);
        step();
        idle_inputs();
        chk("x0_wr_en",    32'(wr_en),      32'd0);
        chk("x0_count",    32'(ld_count),   32'd0);
        chk("x0_busy",     32'(chk_busy_1), 32'd0);
        step();
        chk("x0_wr_en_2",  32'(wr_en),      32'd0);
        chk("x0_rf_x0",    rf[0],           32'd0);
    endtask

    task automatic test_reset_mid();
        // x22 is only visible on wr_* for the instant before reset lands; it never commits.
        expect_wr(5'd20, 32'h20);
        alu_wr_en   = 1'b1;
        alu_wr_reg  = 5'd20;
        alu_wr_data = 32'h20;
        ld_valid    = 1'b1;
        ld_wr_reg   = 5'd21;
        ld_wr_data  = 32'h21;
        step();
        alu_wr_reg  = 5'd22;
        alu_wr_data = 32'h22;
        ld_wr_reg   = 5'd23;
        ld_wr_data  = 32'h23;
        step();
        chk("rstm_full", 32'(ld_count), 32'd2);
        alu_wr_reg  = 5'd24;
        alu_wr_data = 32'h24;
        ld_wr_reg   = 5'd25;
        ld_wr_data  = 32'h25;
        rst_n = 1'b0;
        #1;
        chk("rstm_wr_en",    32'(wr_en),    32'd0);
        chk("rstm_count",    32'(ld_count), 32'd0);
        chk("rstm_ld_ready", 32'(ld_ready), 32'd0);
        step();
        chk("rstm_wr_en_edge",  32'(wr_en),    32'd0);
        chk("rstm_ready_edge",  32'(ld_ready), 32'd0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rstm_no_stale", 32'(wr_en), 32'd0);
        end
        chk("rstm_rf_x21", rf[21], 32'd0);
        chk("rstm_rf_x23", rf[23], 32'd0);
        chk("rstm_rf_x24", rf[24], 32'd0);
        chk("rstm_rf_x22", rf[22], 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_random();
        int  txn;
        int  cyc;
        bit  xfer;
        sb_en = 1'b0;
        for (int r = 0; r < 32; r++) arch[r] = rf[r];
        txn = 0;
        cyc = 0;
        idle_inputs();
        while (txn < 1000 && cyc < 20000) begin
            chk_reg_1 = 5'($urandom_range(0, 7));
            chk_reg_2 = 5'($urandom_range(0, 31));
            #1;
            if (!chk_busy_1) chk("rand_stale_1", rf[chk_reg_1], arch[chk_reg_1]);
            if (!chk_busy_2) chk("rand_stale_2", rf[chk_reg_2], arch[chk_reg_2]);
            alu_wr_en   = ($urandom_range(0, 9) < 6);
            alu_wr_reg  = 5'($urandom_range(0, 7));
            alu_wr_data = $urandom;
            if (!ld_valid) begin
                ld_valid   = ($urandom_range(0, 9) < 6);
                ld_wr_reg  = 5'($urandom_range(0, 7));
                ld_wr_data = $urandom;
            end
            xfer = ld_valid && ld_ready;
            @(posedge clk);
            // Program order: an accepted load precedes a same-cycle ALU result.
            if (xfer) begin
                txn++;
                if (ld_wr_reg != 5'd0) arch[ld_wr_reg] = ld_wr_data;
            end
            if (alu_wr_en) begin
                txn++;
                if (alu_wr_reg != 5'd0) arch[alu_wr_reg] = alu_wr_data;
            end
            #1;
            if (xfer) ld_valid = 1'b0;
            cyc++;
        end
        idle_inputs();
        chk("rand_budget", 32'(txn >= 1000), 32'd1);
        for (int c = 0; c < 8; c++) step();
        chk("rand_drained_cnt", 32'(ld_count), 32'd0);
        chk("rand_drained_wr",  32'(wr_en),    32'd0);
        for (int r = 1; r < 32; r++) chk($sformatf("rand_final_x%0d", r), rf[r], arch[r]);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sb_en  = 1'b1;
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        test_reset();
        test_lone_load();
        test_collision();
        test_backpressure();
        test_waw();
        test_x0();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
